// File: rtl/alsu_pkg.sv
// alsu_pkg: shared definitions for the pipelined ALSU.
//   OPC_*      : 3-bit opcode encodings.
//   alsu_op_t  : control fields captured in the stage-1 register alongside the operands.
package alsu_pkg;

    localparam logic [2:0] OPC_AND   = 3'b000;
    localparam logic [2:0] OPC_XOR   = 3'b001;
    localparam logic [2:0] OPC_ADD   = 3'b010;
    localparam logic [2:0] OPC_MUL   = 3'b011;
    localparam logic [2:0] OPC_SHIFT = 3'b100;
    localparam logic [2:0] OPC_ROT   = 3'b101;
    localparam logic [2:0] OPC_INV6  = 3'b110;
    localparam logic [2:0] OPC_INV7  = 3'b111;

    // Operands are WIDTH-dependent, so they are stored beside this struct
    // rather than inside it.
    typedef struct packed {
        logic [2:0] opc;
        logic       cin;
        logic       sin;
        logic       dir;
        logic       rop_a;
        logic       rop_b;
        logic       bp_a;
        logic       bp_b;
    } alsu_op_t;

endpackage

// File: rtl/alsu_core.sv
// alsu_core: purely combinational result / error calculator.
//   a, b : operands (WIDTH bits)
//   op   : opcode and control flags
//   acc  : current shift/rotate accumulator (OUT_W bits)
//   res  : result (OUT_W bits), zero when err is set
//   err  : the operation is invalid
module alsu_core
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    localparam int   OUT_W          = 2 * WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alsu_op_t         op,
    input  logic [OUT_W-1:0] acc,
    output logic [OUT_W-1:0] res,
    output logic             err
);

    localparam bit PRIO_B  = (INPUT_PRIORITY == "B");
    localparam bit ADD_CIN = (FULL_ADDER == "ON");

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic             cin_eff;

    assign a_ext   = OUT_W'(a);
    assign b_ext   = OUT_W'(b);
    assign cin_eff = ADD_CIN & op.cin;

    always_comb begin
        res = '0;
        err = 1'b0;
        // Bypass outranks every opcode, including the invalid ones.
        if (op.bp_a ^ op.bp_b) begin
            res = op.bp_a ? a_ext : b_ext;
        end else if (op.bp_a && op.bp_b) begin
            res = PRIO_B ? b_ext : a_ext;
        end else if ((op.opc == OPC_AND || op.opc == OPC_XOR) && op.rop_a && op.rop_b) begin
            err = 1'b1;
        end else begin
            case (op.opc)
                OPC_AND: begin
                    if (op.rop_a)      res = OUT_W'(&a);
                    else if (op.rop_b) res = OUT_W'(&b);
                    else               res = a_ext & b_ext;
                end
                OPC_XOR: begin
                    if (op.rop_a)      res = OUT_W'(^a);
                    else if (op.rop_b) res = OUT_W'(^b);
                    else               res = a_ext ^ b_ext;
                end
                // Computed at OUT_W so the carry-out lands in the upper bits.
                OPC_ADD:   res = a_ext + b_ext + OUT_W'(cin_eff);
                OPC_MUL:   res = a_ext * b_ext;
                OPC_SHIFT: res = op.dir ? {acc[OUT_W-2:0], op.sin} : {op.sin, acc[OUT_W-1:1]};
                OPC_ROT:   res = op.dir ? {acc[OUT_W-2:0], acc[OUT_W-1]} : {acc[0], acc[OUT_W-1:1]};
                default:   err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage pipelined ALSU with valid/ready on both sides.
//   clk, rst (async, active-low)
//   in_valid/in_ready + a, b, opc, cin, sin, dir, rop_a, rop_b, bp_a, bp_b : operation input
//   out_valid/out_ready + out, err : result output (err qualified by out_valid)
//   leds : toggles on every result that carries err
// Stage 1 captures the operation; stage 2 holds the computed result. The
// shift/rotate accumulator follows each result as it enters stage 2, so
// chained shifts need no bubble and a stalled stage 2 never re-applies one.
module alsu_pipe
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16,
    localparam int   OUT_W          = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opc,
    input  logic             cin,
    input  logic             sin,
    input  logic             dir,
    input  logic             rop_a,
    input  logic             rop_b,
    input  logic             bp_a,
    input  logic             bp_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             err,
    output logic [LED_W-1:0] leds
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    alsu_op_t         s1_op_q, s1_op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [LED_W-1:0] leds_q, leds_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             s1_adv;
    logic [OUT_W-1:0] core_res;
    logic             core_err;

    assign s1_adv    = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || s1_adv;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = s2_valid_q && out_ready;
    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign err       = err_q;
    assign leds      = leds_q;

    alsu_core #(
        .WIDTH          (WIDTH),
        .INPUT_PRIORITY (INPUT_PRIORITY),
        .FULL_ADDER     (FULL_ADDER)
    ) u_core (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .op  (s1_op_q),
        .acc (acc_q),
        .res (core_res),
        .err (core_err)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (in_xfer) begin
            s1_valid_d    = 1'b1;
            s1_a_d        = a;
            s1_b_d        = b;
            s1_op_d.opc   = opc;
            s1_op_d.cin   = cin;
            s1_op_d.sin   = sin;
            s1_op_d.dir   = dir;
            s1_op_d.rop_a = rop_a;
            s1_op_d.rop_b = rop_b;
            s1_op_d.bp_a  = bp_a;
            s1_op_d.bp_b  = bp_b;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        err_d      = err_q;
        acc_d      = acc_q;
        leds_d     = leds_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            out_d      = core_res;
            err_d      = core_err;
            acc_d      = core_res;
            if (core_err) leds_d = ~leds_q;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            err_q      <= 1'b0;
            acc_q      <= '0;
            leds_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            err_q      <= err_d;
            acc_q      <= acc_d;
            leds_q     <= leds_d;
        end
    end

endmodule

// File: tb/tb_alsu_pipe.sv
// Scoreboard bench for alsu_pipe: two instances (INPUT_PRIORITY "A" and "B")
// share all inputs; expected results are queued at each input transfer and
// popped by an independent monitor at each output transfer.
module tb_alsu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  a = '0, b = '0, opc = '0;
    logic        cin = 1'b0, sin = 1'b0, dir = 1'b0;
    logic        rop_a = 1'b0, rop_b = 1'b0, bp_a = 1'b0, bp_b = 1'b0;

    logic        in_ready_a, out_valid_a, err_a;
    logic [5:0]  out_a;
    logic [15:0] leds_a;
    logic        in_ready_b, out_valid_b, err_b;
    logic [5:0]  out_b;
    logic [15:0] leds_b;

    always #5 clk = ~clk;

    alsu_pipe #(.WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .a(a), .b(b), .opc(opc), .cin(cin), .sin(sin), .dir(dir),
        .rop_a(rop_a), .rop_b(rop_b), .bp_a(bp_a), .bp_b(bp_b),
        .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a), .err(err_a), .leds(leds_a)
    );

    alsu_pipe #(.WIDTH(3), .INPUT_PRIORITY("B"), .FULL_ADDER("ON"), .LED_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .a(a), .b(b), .opc(opc), .cin(cin), .sin(sin), .dir(dir),
        .rop_a(rop_a), .rop_b(rop_b), .bp_a(bp_a), .bp_b(bp_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b), .err(err_b), .leds(leds_b)
    );

    typedef struct {
        logic [5:0]  res_a;
        logic [5:0]  res_b;
        logic        err;
        logic [15:0] leds;
        bit          has_c;
        logic [5:0]  c_res_a;
        logic [5:0]  c_res_b;
        logic        c_err;
        logic [15:0] c_leds;
        bit          consec;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   m_acc_a = 0;
    int   m_acc_b = 0;
    int   m_errs = 0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain arithmetic on integers, 6-bit result space.
    function automatic logic [6:0] ref_alu(input int o, input int av, input int bv,
                                           input int ci, input int si, input int di,
                                           input int ra, input int rb, input int pa,
                                           input int pb, input int acc, input bit prio_b);
        int r;
        bit e;
        r = 0;
        e = 1'b0;
        if (pa != pb)                       r = (pa != 0) ? av : bv;
        else if (pa != 0)                   r = prio_b ? bv : av;
        else if (o < 2 && ra != 0 && rb != 0) e = 1'b1;
        else begin
            case (o)
                0: r = (ra != 0) ? int'(av == 7) : (rb != 0) ? int'(bv == 7) : (av & bv);
                1: r = (ra != 0) ? ($countones(av) % 2) : (rb != 0) ? ($countones(bv) % 2) : (av ^ bv);
                2: r = av + bv + ci;
                3: r = av * bv;
                4: r = (di != 0) ? ((acc * 2) % 64 + si) : (acc / 2 + si * 32);
                5: r = (di != 0) ? ((acc * 2) % 64 + acc / 32) : (acc / 2 + (acc % 2) * 32);
                default: e = 1'b1;
            endcase
        end
        return {e, r[5:0]};
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        a = '0; b = '0; opc = '0; cin = 1'b0; sin = 1'b0; dir = 1'b0;
        rop_a = 1'b0; rop_b = 1'b0; bp_a = 1'b0; bp_b = 1'b0;
    endtask

    // Present the current stimulus and push its expectation when accepted.
    // Must be called just after a rising edge; returns just after the accepting edge.
    task automatic send(input bit hc, input logic [5:0] ca, input logic [5:0] cb,
                        input logic ce, input logic [15:0] cl, input bit cs);
        exp_t       e;
        logic [6:0] ra_v, rb_v;
        bit         done;
        int         w;
        in_valid = 1'b1;
        done = 1'b0;
        w = 0;
        while (!done && w < 200) begin
            @(negedge clk);
            if (in_ready_a) begin
                ra_v = ref_alu(int'(opc), int'(a), int'(b), int'(cin), int'(sin), int'(dir),
                               int'(rop_a), int'(rop_b), int'(bp_a), int'(bp_b), m_acc_a, 1'b0);
                rb_v = ref_alu(int'(opc), int'(a), int'(b), int'(cin), int'(sin), int'(dir),
                               int'(rop_a), int'(rop_b), int'(bp_a), int'(bp_b), m_acc_b, 1'b1);
                e.res_a = ra_v[5:0];
                e.res_b = rb_v[5:0];
                e.err   = ra_v[6];
                m_acc_a = int'(ra_v[5:0]);
                m_acc_b = int'(rb_v[5:0]);
                if (ra_v[6]) m_errs++;
                e.leds    = (m_errs % 2 == 1) ? 16'hFFFF : 16'h0000;
                e.has_c   = hc;
                e.c_res_a = ca;
                e.c_res_b = cb;
                e.c_err   = ce;
                e.c_leds  = cl;
                e.consec  = cs;
                sb.push_back(e);
                done = 1'b1;
            end
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
    endtask

    task automatic send_rand();
        opc   = 3'($urandom_range(0, 7));
        a     = 3'($urandom_range(0, 7));
        b     = 3'($urandom_range(0, 7));
        cin   = 1'($urandom_range(0, 1));
        sin   = 1'($urandom_range(0, 1));
        dir   = 1'($urandom_range(0, 1));
        rop_a = 1'($urandom_range(0, 3) == 0);
        rop_b = 1'($urandom_range(0, 3) == 0);
        bp_a  = 1'($urandom_range(0, 7) == 0);
        bp_b  = 1'($urandom_range(0, 7) == 0);
        send(1'b0, 6'd0, 6'd0, 1'b0, 16'h0, 1'b0);
    endtask

    // Monitor: pops on every output transfer; checks hold-stability under stall.
    exp_t       mon_e;
    bit         prev_stall = 1'b0;
    logic [5:0] prev_out;
    logic       prev_err;
    int         last_pop = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else if (out_valid_a && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: out=%0h with empty scoreboard, expected no output", out_a);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_a", 32'(out_a), 32'(mon_e.res_a));
                    chk("err_a", 32'(err_a), 32'(mon_e.err));
                    chk("out_b", 32'(out_b), 32'(mon_e.res_b));
                    chk("leds_a", 32'(leds_a), 32'(mon_e.leds));
                    if (mon_e.has_c) begin
                        chk("dir_out_a", 32'(out_a), 32'(mon_e.c_res_a));
                        chk("dir_out_b", 32'(out_b), 32'(mon_e.c_res_b));
                        chk("dir_err", 32'(err_a), 32'(mon_e.c_err));
                        chk("dir_leds", 32'(leds_a), 32'(mon_e.c_leds));
                    end
                    if (mon_e.consec) chk("no_bubble", 32'(cyc - last_pop), 32'd1);
                end
                last_pop = cyc;
                prev_stall = 1'b0;
            end else if (out_valid_a) begin
                if (prev_stall) begin
                    chk("stall_out", 32'(out_a), 32'(prev_out));
                    chk("stall_err", 32'(err_a), 32'(prev_err));
                end
                prev_out = out_a;
                prev_err = err_a;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        // Reset values while held, then fill and stall the pipe.
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out", 32'(out_a), 32'd0);
        align();
        rst = 1'b1;
        align();
        out_ready = 1'b0;
        clr(); opc = 3'd6;
        send(1'b0, 6'd0, 6'd0, 1'b0, 16'h0, 1'b0);
        clr(); opc = 3'd3; a = 3'd3; b = 3'd2;
        send(1'b0, 6'd0, 6'd0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready_a), 32'd0);
        chk("full_out_valid", 32'(out_valid_a), 32'd1);
        chk("full_leds", 32'(leds_a), 32'hFFFF);
        // Asynchronous reset mid-stall discards both queued results.
        @(posedge clk);
        #3;
        rst = 1'b0;
        sb.delete();
        m_acc_a = 0; m_acc_b = 0; m_errs = 0;
        #1;
        chk("arst_out_valid", 32'(out_valid_a), 32'd0);
        chk("arst_out", 32'(out_a), 32'd0);
        chk("arst_err", 32'(err_a), 32'd0);
        chk("arst_leds", 32'(leds_a), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready_a), 32'd1);
        chk("rel_out_valid", 32'(out_valid_a), 32'd0);
        chk("rel_leds", 32'(leds_a), 32'd0);

        // ADD with carry, then latency, then MUL.
        align();
        out_ready = 1'b1;
        clr(); opc = 3'd2; a = 3'd7; b = 3'd7; cin = 1'b1;
        send(1'b1, 6'd15, 6'd15, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk("lat_edge_n", 32'(out_valid_a), 32'd0);
        @(negedge clk);
        chk("lat_edge_n1", 32'(out_valid_a), 32'd1);
        align();
        clr(); opc = 3'd3; a = 3'd7; b = 3'd7;
        send(1'b1, 6'd49, 6'd49, 1'b0, 16'h0, 1'b0);

        // Dual bypass: priority decides.
        clr(); a = 3'd5; b = 3'd2; bp_a = 1'b1; bp_b = 1'b1;
        send(1'b1, 6'd5, 6'd2, 1'b0, 16'h0, 1'b0);

        // Chained shift / rotate, back to back.
        clr(); a = 3'd1; bp_a = 1'b1;
        send(1'b1, 6'd1, 6'd1, 1'b0, 16'h0, 1'b0);
        clr(); opc = 3'd4; dir = 1'b1; sin = 1'b1;
        send(1'b1, 6'd3, 6'd3, 1'b0, 16'h0, 1'b1);
        clr(); opc = 3'd5; dir = 1'b0;
        send(1'b1, 6'd33, 6'd33, 1'b0, 16'h0, 1'b1);
        clr(); opc = 3'd5; dir = 1'b1;
        send(1'b1, 6'd3, 6'd3, 1'b0, 16'h0, 1'b1);

        // Invalid operations toggle leds.
        clr(); opc = 3'd6;
        send(1'b1, 6'd0, 6'd0, 1'b1, 16'hFFFF, 1'b0);
        clr(); opc = 3'd0; rop_a = 1'b1; rop_b = 1'b1;
        send(1'b1, 6'd0, 6'd0, 1'b1, 16'h0000, 1'b0);

        // Backpressure: fill, stall three cycles, drain in order.
        repeat (4) align();
        out_ready = 1'b0;
        clr(); opc = 3'd2; a = 3'd6; b = 3'd3;
        send(1'b1, 6'd9, 6'd9, 1'b0, 16'h0, 1'b0);
        clr(); opc = 3'd1; a = 3'd6; b = 3'd3;
        send(1'b1, 6'd5, 6'd5, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready_a), 32'd0);
            chk("stall_out_valid", 32'(out_valid_a), 32'd1);
        end
        align();
        out_ready = 1'b1;
        repeat (4) align();

        // Randomized traffic under random backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) align();
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alsu_pipe.md
Name: alsu_pipe

Overview:
- Parametrised, pipelined successor to the team's 3-bit ALSU.
- Operands are WIDTH bits wide. The result is 2*WIDTH bits wide.
- Input and output both use a valid/ready handshake, so the block can sit between a stimulus FIFO and a result/LED display stage under backpressure.
- Adds a per-result error flag and a shift/rotate accumulator that is preserved across stalls.

Parameters:
- WIDTH, 3, operand width in bits; localparam OUT_W = 2*WIDTH.
- INPUT_PRIORITY, "A", operand passed through when bp_a and bp_b are both high ("A" or "B").
- FULL_ADDER, "ON", "ON" adds cin in the ADD opcode; "OFF" ignores cin.
- LED_W, 16, width of the leds output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opc  in  3  opcode.
- cin  in  1  carry in.
- sin  in  1  serial-in bit for shift.
- dir  in  1  1 = left, 0 = right.
- rop_a  in  1  reduction on A.
- rop_b  in  1  reduction on B.
- bp_a  in  1  bypass A.
- bp_b  in  1  bypass B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out  out  OUT_W  result.
- err  out  1  result came from an invalid operation; qualified by out_valid.
- leds  out  LED_W  error indicator.

Behaviour:
- Reset (rst=0, asynchronous, any cycle including mid-stall):
  - s1_valid and s2_valid = 0.
  - out, acc, leds = 0; err = 0.
  - in_ready = 1 from the first edge after release.
- Handshake:
  - Transfer at input when in_valid && in_ready. Transfer at output when out_valid && out_ready.
  - out, err and out_valid stay stable while out_valid && !out_ready.
- Stage 1 (s1) registers all inputs on an input transfer.
  - s1 advances to s2 when !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_advance.
  - Full throughput is one operation per cycle.
- Stage 2 (s2) holds the result, computed from s1 plus acc.
  - Latency is 2 edges: an op accepted at edge N is presented after edge N+1 when no stall occurs.
- Priority of result selection (the err cases yield out=0, err=1):
  1. bp_a xor bp_b: the bypassed operand, zero-extended.
  2. bp_a && bp_b: the operand selected by INPUT_PRIORITY.
  3. opcode 000 or 001 with rop_a && rop_b: invalid.
  4. Otherwise by opcode:
     - 000: rop_a → &a, else rop_b → &b, else a & b. Zero-extended.
     - 001: the same selection using ^ (xor).
     - 010: a + b (+ cin if FULL_ADDER="ON"), computed at OUT_W; the carry is kept.
     - 011: a * b, full OUT_W product.
     - 100: shift acc. dir=1 → {acc[OUT_W-2:0], sin}; dir=0 → {sin, acc[OUT_W-1:1]}.
     - 101: rotate acc. dir=1 → {acc[OUT_W-2:0], acc[OUT_W-1]}; dir=0 → {acc[0], acc[OUT_W-1:1]}.
     - 110 and 111: invalid.
- acc is updated with each result on its s1→s2 advance, so back-to-back shifts chain with no bubble. A stalled s2 does not re-apply a shift.
- leds invert on every s1→s2 advance that yields err=1; otherwise they are held.
- A reset while s2 is stalled discards both queued results; no partial output occurs.

Decomposition:
- Package alsu_pkg holds:
  - Opcode localparams OPC_AND, OPC_XOR, OPC_ADD, OPC_MUL, OPC_SHIFT, OPC_ROT, OPC_INV6, OPC_INV7.
  - Packed struct alsu_op_t for the s1 register contents.
- Sub-module alsu_core: a purely combinational result/err calculator, parametrised by WIDTH, INPUT_PRIORITY and FULL_ADDER.
- alsu_pipe keeps the handshake, the pipeline registers, acc and leds.

Test Plan:
1. Hold rst=0 with the pipe full and out_ready=0, then release → out=0, err=0, leds=0, out_valid=0, in_ready=1.
2. WIDTH=3: a=7, b=7, cin=1, opc=010 accepted at edge N → out_valid with out=15 after edge N+1. Next op opc=011 → out=49.
3. a=5, b=2, bp_a=bp_b=1 → out=5 with INPUT_PRIORITY="A"; out=2 with "B".
4. After out=1: opc=100, dir=1, sin=1 → 3. Then opc=101, dir=0 → 6'b100001. Then opc=101, dir=1 → 6'b000011. Back-to-back, no bubbles.
5. opc=110, then opc=000 with rop_a=rop_b=1 → two results with out=0, err=1. leds go 0xFFFF, then 0x0000.
6. Pipe full, out_ready=0 for 3 cycles → in_ready=0, out stable. Raising out_ready drains both results in order on consecutive cycles.
